spaceship_collision_collector: RTL

Receiving end of the bitmap drawers' `drawingRequest`/`HitEdgeCode` outputs. Watches pixel-aligned drawing requests from the spaceship, alien, shot and border objects during each frame. Accumulates overlaps into per-frame collision flags and an OR of the spaceship's hit-edge codes. On each frame boundary it reports them as one-cycle pulses, applies a post-hit invulnerability cooldown, and keeps a saturating hit counter. It sits between the object drawers and the game-control logic.

---
 rtl/spaceship_collision_collector.sv | 100 ++++++++++
 1 files changed

// File: rtl/spaceship_collision_collector.sv
// spaceship_collision_collector: accumulates per-frame object overlaps and reports them as
// one-cycle pulses at each frame boundary, with post-hit cooldown and a saturating hit counter.
module spaceship_collision_collector #(
    parameter int COOLDOWN_FRAMES = 60,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               spaceshipDR,
    input  logic [3:0]         spaceshipHitEdge,
    input  logic               alienDR,
    input  logic               shotDR,
    input  logic               borderDR,
    input  logic               clearCount,
    output logic               shipHit,
    output logic               shotHitAlien,
    output logic               shipHitBorder,
    output logic [3:0]         edgeCode,
    output logic               invulnerable,
    output logic [COUNT_W-1:0] hitCount
);
    localparam int CD_W = COOLDOWN_FRAMES > 0 ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    typedef enum logic {ARMED, COOLDOWN} state_t;

    state_t          state;
    logic [CD_W-1:0] cd_cnt;
    logic            acc_sa, acc_xa, acc_sb;
    logic [3:0]      acc_edge;
    logic            sa, xa, sb;
    logic [3:0]      cur_edge;
    logic            report_hit;

    assign sa         = spaceshipDR & alienDR;
    assign xa         = shotDR & alienDR;
    assign sb         = spaceshipDR & borderDR;
    assign cur_edge   = sb ? spaceshipHitEdge : 4'h0;
    assign report_hit = startOfFrame & acc_sa & (state == ARMED);

    // Overlaps coincident with startOfFrame seed the new frame rather than the reported one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shipHit       <= 1'b0;
            shotHitAlien  <= 1'b0;
            shipHitBorder <= 1'b0;
            edgeCode      <= 4'h0;
            acc_sa        <= 1'b0;
            acc_xa        <= 1'b0;
            acc_sb        <= 1'b0;
            acc_edge      <= 4'h0;
        end else begin
            shipHit       <= report_hit;
            shotHitAlien  <= startOfFrame & acc_xa;
            shipHitBorder <= startOfFrame & acc_sb;
            if (startOfFrame) begin
                edgeCode <= acc_edge;
                acc_sa   <= sa;
                acc_xa   <= xa;
                acc_sb   <= sb;
                acc_edge <= cur_edge;
            end else begin
                acc_sa   <= acc_sa | sa;
                acc_xa   <= acc_xa | xa;
                acc_sb   <= acc_sb | sb;
                acc_edge <= acc_edge | cur_edge;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ARMED;
            cd_cnt       <= '0;
            invulnerable <= 1'b0;
        end else if (startOfFrame) begin
            if (state == ARMED) begin
                if (acc_sa && COOLDOWN_FRAMES > 0) begin
                    state        <= COOLDOWN;
                    cd_cnt       <= CD_W'(COOLDOWN_FRAMES);
                    invulnerable <= 1'b1;
                end
            end else if (cd_cnt == CD_W'(1)) begin
                state        <= ARMED;
                invulnerable <= 1'b0;
            end else begin
                cd_cnt <= cd_cnt - CD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hitCount <= '0;
        else if (clearCount)
            hitCount <= '0;
        else if (shipHit && hitCount != '1)
            hitCount <= hitCount + COUNT_W'(1);
    end
endmodule
